// File: rtl/audio_pkg.sv
// Shared audio constants and the 13->12 bit signed saturator used by the
// decimator and the downstream audio handling stage.
package audio_pkg;

    localparam int ADC_W     = 12;
    localparam int ADC_MID   = 2048;
    localparam int AUDIO_MAX = 2047;
    localparam int AUDIO_MIN = -2048;

    // Overflow of a 13-bit value into 12 bits shows as disagreeing top bits.
    function automatic logic sat_hit(input logic signed [12:0] v);
        return v[12] ^ v[11];
    endfunction

    function automatic logic signed [11:0] saturate(input logic signed [12:0] v);
        if (sat_hit(v)) begin
            return v[12] ? 12'sh800 : 12'sh7FF;
        end
        return v[11:0];
    endfunction

endpackage

// File: rtl/audio_decimator_peak_meter.sv
// Windowed peak-magnitude meter over the decimated audio stream.
module peak_meter
    import audio_pkg::*;
#(
    parameter int PEAK_WIN_LOG2 = 12
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 audio_valid,
    input  logic [ADC_W-1:0]     audio_out,
    output logic [ADC_W-2:0]     peak_out,
    output logic                 peak_valid
);

    logic [ADC_W-2:0]         run_q, run_d;
    logic [ADC_W-2:0]         peak_q, peak_d;
    logic                     pv_q, pv_d;
    logic [PEAK_WIN_LOG2-1:0] win_q, win_d;
    logic [ADC_W-1:0]         abs_val;
    logic [ADC_W-2:0]         mag;
    logic [ADC_W-2:0]         cand;

    always_comb begin
        // |-2048| does not fit in 11 bits, so it is pinned to 2047.
        abs_val = audio_out[ADC_W-1] ? (~audio_out + 1'b1) : audio_out;
        mag     = abs_val[ADC_W-1] ? '1 : abs_val[ADC_W-2:0];
        cand    = (mag > run_q) ? mag : run_q;
        run_d   = run_q;
        peak_d  = peak_q;
        win_d   = win_q;
        pv_d    = 1'b0;
        if (audio_valid) begin
            win_d = win_q + 1'b1;
            if (&win_q) begin
                peak_d = cand;
                pv_d   = 1'b1;
                run_d  = '0;
            end else begin
                run_d  = cand;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            peak_q <= '0;
            pv_q   <= 1'b0;
            win_q  <= '0;
        end else begin
            run_q  <= run_d;
            peak_q <= peak_d;
            pv_q   <= pv_d;
            win_q  <= win_d;
        end
    end

    assign peak_out   = peak_q;
    assign peak_valid = pv_q;

endmodule

// File: rtl/audio_decimator.sv
// Boxcar decimator, first-order IIR DC remover and saturator for one
// AD9226 audio channel, with a windowed peak meter for gain monitoring.
module audio_decimator
    import audio_pkg::*;
#(
    parameter int DEC_LOG2      = 8,
    parameter int DC_SHIFT      = 10,
    parameter int PEAK_WIN_LOG2 = 12
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] audio_out,
    output logic             audio_valid,
    output logic             clip,
    output logic [ADC_W-2:0] peak_out,
    output logic             peak_valid
);

    localparam int AW = ADC_W + DEC_LOG2;
    localparam int DW = ADC_W + DC_SHIFT;

    logic signed [ADC_W-1:0] x;
    logic signed [AW-1:0]    x_ext;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [DEC_LOG2-1:0]     cnt_q, cnt_d;
    logic                    blk_q, blk_d;
    logic signed [ADC_W-1:0] avg_q, avg_d;
    logic                    s1_q, s1_d;
    logic signed [DW-1:0]    dc_acc_q, dc_acc_d;
    logic signed [ADC_W-1:0] dc_est;
    logic signed [ADC_W:0]   diff;
    logic [ADC_W-1:0]        audio_q, audio_d;
    logic                    valid_q, valid_d;
    logic                    clip_q, clip_d;

    // Offset-binary to two's complement is a flip of the MSB.
    assign x     = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
    assign x_ext = {{DEC_LOG2{x[ADC_W-1]}}, x};

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        blk_d = 1'b0;
        if (sample_en) begin
            acc_d = (cnt_q == '0) ? x_ext : acc_q + x_ext;
            cnt_d = cnt_q + 1'b1;
            blk_d = &cnt_q;
        end
    end

    // After the completing edge acc_q already holds acc + x, so stage 1
    // takes its top bits: an arithmetic floor divide by 2^DEC_LOG2.
    always_comb begin
        s1_d  = blk_q;
        avg_d = blk_q ? acc_q[AW-1:DEC_LOG2] : avg_q;
    end

    always_comb begin
        dc_est   = dc_acc_q[DW-1:DC_SHIFT];
        diff     = {avg_q[ADC_W-1], avg_q} - {dc_est[ADC_W-1], dc_est};
        valid_d  = s1_q;
        audio_d  = audio_q;
        clip_d   = 1'b0;
        dc_acc_d = dc_acc_q;
        if (s1_q) begin
            audio_d  = saturate(diff);
            clip_d   = sat_hit(diff);
            dc_acc_d = dc_acc_q + {{(DW-ADC_W-1){diff[ADC_W]}}, diff};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            blk_q    <= 1'b0;
            avg_q    <= '0;
            s1_q     <= 1'b0;
            dc_acc_q <= '0;
            audio_q  <= '0;
            valid_q  <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            blk_q    <= blk_d;
            avg_q    <= avg_d;
            s1_q     <= s1_d;
            dc_acc_q <= dc_acc_d;
            audio_q  <= audio_d;
            valid_q  <= valid_d;
            clip_q   <= clip_d;
        end
    end

    assign audio_out   = audio_q;
    assign audio_valid = valid_q;
    assign clip        = clip_q;

    peak_meter #(
        .PEAK_WIN_LOG2 (PEAK_WIN_LOG2)
    ) u_peak (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .audio_valid (valid_q),
        .audio_out   (audio_q),
        .peak_out    (peak_out),
        .peak_valid  (peak_valid)
    );

endmodule

// File: tb/tb_audio_decimator.sv
// Self-checking bench for audio_decimator: hand-computed vector table plus
// model-driven scoreboard runs for DC tracking, clipping, reset and stalls.
module tb_audio_decimator;

    localparam int DL = 2;
    localparam int DS = 10;
    localparam int PW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sample_en = 1'b0;
    logic [11:0] adc_data = 12'd2048;
    logic [11:0] audio_out;
    logic        audio_valid;
    logic        clip;
    logic [10:0] peak_out;
    logic        peak_valid;

    always #5 clk = ~clk;

    audio_decimator #(
        .DEC_LOG2      (DL),
        .DC_SHIFT      (DS),
        .PEAK_WIN_LOG2 (PW)
    ) dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .adc_data    (adc_data),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .clip        (clip),
        .peak_out    (peak_out),
        .peak_valid  (peak_valid)
    );

    typedef struct { int val; bit clp; int cyc; } aexp_t;
    typedef struct { int val; int cyc; } pexp_t;
    typedef struct { bit rst; logic [11:0] s [4]; int out; bit clp; int peak; } vec_t;

    aexp_t aq[$];
    pexp_t pq[$];
    vec_t  tbl[13];

    int total = 0, bad = 0, cyc = 0;
    int last_edge = 0;
    bit use_model = 1'b0;
    int m_sum = 0, m_cnt = 0, m_dc = 0, m_run = 0, m_win = 0;
    int last_a = 0, prev_a = 0, mono_bad = 0, n_valid = 0, first_cyc = 0;
    int fv0 = 0, fv1 = 0;
    bit last_clip = 1'b0, mono_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(bit r, int s0, int s1, int s2, int s3, int o, bit c, int p);
        vec_t v;
        v.rst = r;
        v.s[0] = 12'(s0); v.s[1] = 12'(s1); v.s[2] = 12'(s2); v.s[3] = 12'(s3);
        v.out = o; v.clp = c; v.peak = p;
        return v;
    endfunction

    task automatic model_block(input int e);
        int avg, est, diff, o, mag;
        bit c;
        avg  = m_sum >>> DL;
        est  = m_dc >>> DS;
        diff = avg - est;
        c    = (diff > 2047) || (diff < -2048);
        o    = (diff > 2047) ? 2047 : (diff < -2048) ? -2048 : diff;
        m_dc = m_dc + diff;
        aq.push_back('{o, c, e + 2});
        mag = (o < 0) ? -o : o;
        if (mag > 2047) mag = 2047;
        if (mag < m_run) mag = m_run;
        m_win++;
        if (m_win == (1 << PW)) begin
            pq.push_back('{mag, e + 3});
            m_run = 0;
            m_win = 0;
        end else begin
            m_run = mag;
        end
    endtask

    task automatic model_sample(input logic [11:0] d, input int e);
        int x;
        x = int'(d) - 2048;
        m_sum = (m_cnt == 0) ? x : m_sum + x;
        m_cnt++;
        if (m_cnt == (1 << DL)) begin
            m_cnt = 0;
            model_block(e);
        end
    endtask

    task automatic step(input bit en, input logic [11:0] d);
        int e;
        sample_en = en;
        adc_data  = d;
        @(posedge clk);
        e = cyc + 1;
        last_edge = e;
        if (en && use_model) model_sample(d, e);
        #1;
    endtask

    task automatic do_reset();
        repeat (4) step(1'b0, 12'd2048);
        chk("drain_audio", aq.size(), 0);
        chk("drain_peak", pq.size(), 0);
        rst_n = 1'b0;
        #2;
        chk("reset_outputs", int'({audio_out, audio_valid, clip, peak_out, peak_valid}), 0);
        aq.delete();
        pq.delete();
        m_sum = 0; m_cnt = 0; m_dc = 0; m_run = 0; m_win = 0;
        n_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        int a;
        aexp_t ea;
        pexp_t ep;
        if (rst_n) begin
            a = int'($signed(audio_out));
            if (audio_valid) begin
                n_valid++;
                if (n_valid == 1) begin first_cyc = cyc; fv0 = a; end
                if (n_valid == 2) fv1 = a;
                last_a = a;
                last_clip = clip;
                if (mono_en) begin
                    if (a > prev_a) mono_bad++;
                    prev_a = a;
                end
                total++;
                if (aq.size() == 0) begin
                    bad++;
                    $display("FAIL audio_unexpected: got out=%0d clip=%0b at cycle %0d, required no pulse", a, clip, cyc);
                end else begin
                    ea = aq.pop_front();
                    if (a != ea.val || clip != ea.clp || cyc != ea.cyc) begin
                        bad++;
                        $display("FAIL audio_sample: got out=%0d clip=%0b cycle=%0d, required out=%0d clip=%0b cycle=%0d",
                                 a, clip, cyc, ea.val, ea.clp, ea.cyc);
                    end
                end
            end else if (aq.size() > 0 && aq[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL audio_missing: got no pulse at cycle %0d, required out=%0d", cyc, aq[0].val);
                void'(aq.pop_front());
            end
            if (peak_valid) begin
                total++;
                if (pq.size() == 0) begin
                    bad++;
                    $display("FAIL peak_unexpected: got peak=%0d at cycle %0d, required no pulse", peak_out, cyc);
                end else begin
                    ep = pq.pop_front();
                    if (int'(peak_out) != ep.val || cyc != ep.cyc) begin
                        bad++;
                        $display("FAIL peak_sample: got peak=%0d cycle=%0d, required peak=%0d cycle=%0d",
                                 peak_out, cyc, ep.val, ep.cyc);
                    end
                end
            end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL peak_missing: got no pulse at cycle %0d, required peak=%0d", cyc, pq[0].val);
                void'(pq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        // Hand-computed blocks, DEC_LOG2=2, DC_SHIFT=10, 4-output peak window.
        tbl[0]  = mk(1'b1, 2052, 2056, 2060, 2064,    10, 1'b0,   -1);
        tbl[1]  = mk(1'b0, 2047, 2047, 2047, 2046,    -2, 1'b0,   -1);
        tbl[2]  = mk(1'b0, 4095, 4095, 4095, 4095,  2047, 1'b0,   -1);
        tbl[3]  = mk(1'b0,    0,    0,    0,    0, -2048, 1'b1, 2047);
        tbl[4]  = mk(1'b0, 2049, 2048, 2048, 2048,     0, 1'b0,   -1);
        tbl[5]  = mk(1'b1, 2053, 2053, 2053, 2053,     5, 1'b0,   -1);
        tbl[6]  = mk(1'b0, 1748, 1748, 1748, 1748,  -300, 1'b0,   -1);
        tbl[7]  = mk(1'b0, 2054, 2054, 2054, 2054,     7, 1'b0,   -1);
        tbl[8]  = mk(1'b0, 2059, 2059, 2059, 2059,    12, 1'b0,  300);
        tbl[9]  = mk(1'b0, 2048, 2048, 2048, 2048,     1, 1'b0,   -1);
        tbl[10] = mk(1'b0, 2048, 2048, 2048, 2048,     1, 1'b0,   -1);
        tbl[11] = mk(1'b0, 2048, 2048, 2048, 2048,     1, 1'b0,   -1);
        tbl[12] = mk(1'b0, 2048, 2048, 2048, 2048,     1, 1'b0,    1);

        use_model = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            for (int k = 0; k < 4; k++) step(1'b1, tbl[i].s[k]);
            aq.push_back('{tbl[i].out, tbl[i].clp, last_edge + 2});
            if (tbl[i].peak >= 0) pq.push_back('{tbl[i].peak, last_edge + 3});
        end

        // Mid-scale idle: silence, first pulse 6 cycles after release.
        use_model = 1'b1;
        do_reset();
        rel = cyc;
        repeat (64) step(1'b1, 12'd2048);
        chk("idle_first_pulse", first_cyc - rel, 6);

        // DC tracking from a constant +1024 offset.
        do_reset();
        mono_en = 1'b1;
        prev_a = 4096;
        mono_bad = 0;
        repeat (9000 * 4) step(1'b1, 12'd3072);
        repeat (4) step(1'b0, 12'd3072);
        mono_en = 1'b0;
        chk("dc_first", fv0, 1024);
        chk("dc_second", fv1, 1023);
        chk("dc_monotonic_violations", mono_bad, 0);
        chk("dc_settled", int'(last_a <= 2 && last_a >= -2), 1);

        // Clip: drive the tracker negative, then step to full scale.
        do_reset();
        repeat (1000 * 4) step(1'b1, 12'd0);
        repeat (4) step(1'b1, 12'd4095);
        repeat (3) step(1'b0, 12'd4095);
        chk("clip_step_out", last_a, 2047);
        chk("clip_step_flag", int'(last_clip), 1);
        repeat (4) step(1'b1, 12'd4095);

        // Reset mid-block discards the partial block.
        do_reset();
        step(1'b1, 12'd2100);
        step(1'b1, 12'd2100);
        step(1'b0, 12'd2100);
        do_reset();

        // A 3-cycle sample_en gap stretches the block by exactly 3 cycles.
        rel = cyc;
        step(1'b1, 12'd2056);
        step(1'b1, 12'd2056);
        repeat (3) step(1'b0, 12'd0);
        step(1'b1, 12'd2056);
        step(1'b1, 12'd2056);
        repeat (3) step(1'b0, 12'd0);
        chk("stall_first_pulse", first_cyc - rel, 9);
        chk("stall_value", last_a, 8);

        for (int k = 0; k < 120; k++) begin
            step(1'b1, 12'($urandom_range(1400, 2700)));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) step(1'b0, 12'($urandom_range(0, 4095)));
        end

        repeat (6) step(1'b0, 12'd2048);
        chk("final_drain_audio", aq.size(), 0);
        chk("final_drain_peak", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_decimator.md
# audio_decimator

Front-end conditioning stage between an AD9226 capture channel and the audio handling stage. Takes the 12-bit offset-binary ADC stream at the 10 MHz sample clock, boxcar-decimates it to audio rate, removes DC with a first-order IIR, and saturates the result to a 12-bit signed sample with a valid strobe. It also reports a windowed peak level and a clip flag for gain monitoring. One instance is used per audio channel, Move_Fre_SIG channel included.

## Interface
- DEC_LOG2, 8, decimation factor is 2^DEC_LOG2; the default gives 10 MHz / 256 = 39.0625 kS/s.
- DC_SHIFT, 10, IIR DC-tracker coefficient 2^-DC_SHIFT.
- PEAK_WIN_LOG2, 12, peak window length in output samples (2^PEAK_WIN_LOG2).

- clk_in  in  1  sample clock; all logic is on this clock.
- rst_n  in  1  reset; asynchronous, active-low.
- sample_en  in  1  qualifies adc_data; may be held high.
- adc_data  in  12  offset-binary ADC word; 2048 is mid-scale.
- audio_out  out  12  signed two's-complement decimated, DC-free sample.
- audio_valid  out  1  one-cycle pulse when audio_out updates.
- clip  out  1  one-cycle pulse, coincident with audio_valid, when the sample was saturated.
- peak_out  out  11  max |audio_out| over the last completed window, range 0..2047.
- peak_valid  out  1  one-cycle pulse when peak_out updates.

## Operation
- **Input conversion:** x = adc_data − 2048, giving a 12-bit signed value.
- **Accumulator:**
  - acc is signed, 12+DEC_LOG2 bits. cnt is DEC_LOG2 bits.
  - Only cycles with sample_en=1 advance it.
  - On cnt = 0, acc loads x; otherwise acc accumulates x. cnt then increments and wraps.
  - The sample_en cycle with cnt = 2^DEC_LOG2−1 completes a block.
- **Stage 1:** the cycle after block completion registers avg = (acc + x) >>> DEC_LOG2. This is an arithmetic floor; avg is 12-bit signed.
- **Stage 2:** the next cycle computes the DC-removed sample and updates the tracker.
  - dc_est = dc_acc >>> DC_SHIFT. dc_acc is 12+DC_SHIFT bits signed.
  - diff = avg − dc_est, 13-bit signed.
  - audio_out = sat(diff) to [−2048, 2047]. clip = 1 if diff is out of range.
  - dc_acc <= dc_acc + avg − dc_est, using the same-cycle old dc_est. dc_acc cannot overflow because |dc_est| ≤ 2048.
- **Peak meter:**
  - On each audio_valid, mag = min(|audio_out|, 2047) and run_max <= max(run_max, mag).
  - On the 2^PEAK_WIN_LOG2-th valid of a window, peak_out <= max(run_max, mag) and peak_valid pulses. run_max clears to 0 in that cycle, and the current sample is not carried into the next window.
- **sample_en low:** all state holds. Pipeline stages already triggered still complete.
- **Reset values:** audio_out, audio_valid, clip, peak_out and peak_valid are 0. acc, cnt, dc_acc, run_max and window count are 0.
- **Reset mid-block:** the partial block is discarded and no output is produced for it.

## Timing
- Latency: audio_valid asserts exactly 2 cycles after the clk_in edge that samples the block-completing sample_en.
- audio_out holds between pulses.
- clip pulses coincident with audio_valid.
- peak_valid asserts 1 cycle after the window-final audio_valid.
- Minimum output spacing is 2^DEC_LOG2 cycles. No back-pressure; the downstream stage must accept every pulse.
- Back-to-back blocks with sample_en=1 continuously: the pipeline never stalls, and each block's avg is independent.

## Structure
- **Shared package audio_pkg:**
  - ADC_W=12 and ADC_MID=2048.
  - AUDIO_MAX=2047 and AUDIO_MIN=−2048.
  - A saturate function, 13→12 bits signed, reused by the audio handling stage.
- **Sub-module peak_meter:** parameter PEAK_WIN_LOG2; inputs audio_valid and audio_out; outputs peak_out and peak_valid. The decimator and DC path stay in the top of this block.

## Test plan
- **Mid-scale idle:** DEC_LOG2=2; adc_data=2048 constant with sample_en=1 for 64 cycles. Required: audio_out=0 on every pulse, clip=0, pulses every 4 cycles, first pulse on cycle 6 after reset release.
- **Block average:** DEC_LOG2=2; samples 2052, 2056, 2060, 2064. Required: first audio_out=10 (dc_est=0), 2 cycles after the 4th sample.
- **DC tracking:** DEC_LOG2=2, DC_SHIFT=10; constant 3072. Required: outputs 1024, then 1023, then monotonically decaying toward 0. After 20000 outputs, |audio_out| ≤ 2.
- **Clip:** hold 0 until dc_est ≈ −2048, then step to 4095. Required: audio_out=2047 with clip=1 on the step's first output.
- **Peak window:** PEAK_WIN_LOG2=2; outputs 5, −300, 7, 12. Required: peak_valid one cycle after the 4th valid, with peak_out=300. The next window starts from 0.
- **Reset and stall:** assert rst_n low mid-block, then release. Required: no audio_valid for the aborted block and all outputs 0. Gaps in sample_en stretch block length exactly by the gap count.
